// File: rtl/rr_mux_n.sv
// N-channel registered multiplexer with round-robin / fixed-priority arbitration
// and valid/ready handshakes on every input channel and on the output.
module rr_mux_n #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d, sel_data;
  logic [SEL_W-1:0] ch_q, ch_d, sel_ch;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             found, load, xfer;
  logic [31:0]      ptr32, rank, best;
  logic [N_CH-1:0]  grant_oh;

  assign ptr32 = 32'(ptr_q);

  // Each requester gets a rank (its distance from ptr in round-robin mode,
  // its own index in fixed-priority mode); the lowest rank wins.
  always_comb begin
    found    = 1'b0;
    sel_ch   = '0;
    sel_data = '0;
    best     = '0;
    rank     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (mode)
        rank = i;
      else if (i >= ptr32)
        rank = i - ptr32;
      else
        rank = i + N_CH - ptr32;
      if (in_valid[i] && (!found || rank < best)) begin
        found    = 1'b1;
        best     = rank;
        sel_ch   = SEL_W'(i);
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      grant_oh[i] = found && (sel_ch == SEL_W'(i));
  end

  assign load     = !valid_q || out_ready;
  assign xfer     = load && found && !rst;
  assign in_ready = xfer ? grant_oh : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (load)
      valid_d = found;
    if (xfer) begin
      data_d = sel_data;
      ch_d   = sel_ch;
      if (!mode)
        ptr_d = (sel_ch == SEL_W'(N_CH - 1)) ? '0 : sel_ch + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule
